// File: rtl/qspi_flash_arbiter_if.sv
// Requester-side bundle of the shared QSPI flash read controller.
// master = fetch/data requesters, slave = the arbiter.
interface qspi_flash_arbiter_if;
  logic        i_req;
  logic [23:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [23:0] d_addr;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        busy;

  modport master (
    output i_req, i_addr, d_req, d_addr,
    input  i_done, i_rdata, d_done, d_rdata, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_addr,
    output i_done, i_rdata, d_done, d_rdata, busy
  );
endinterface

// File: rtl/qspi_flash_arbiter.sv
// Quad-SPI Fast Read Quad Output controller shared by fetch and data ports.
// Define FLASH_RSTSEQ_EN to send 0x66/0x99 flash reset frames after reset.
module qspi_flash_arbiter #(
  parameter logic [7:0]  RD_CMD     = 8'h6B,
  parameter int unsigned DUMMY_CLKS = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  qspi_flash_arbiter_if.slave  bus,
  input  logic [3:0]           fdi,
  output logic [3:0]           fdo,
  output logic [3:0]           fdoe,
  output logic                 fsclk,
  output logic                 fcen
);

`ifdef FLASH_RSTSEQ_EN
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE,
    S_INIT, S_RST66, S_GAP, S_RST99, S_WAIT
  } state_e;
  localparam state_e     S_RESET  = S_INIT;
  localparam logic [7:0] OP_RSTEN = 8'h66;
  localparam logic [7:0] OP_RST   = 8'h99;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
  } state_e;
  localparam state_e S_RESET = S_IDLE;
`endif

  localparam logic [6:0] DUMMY_LAST = 7'(DUMMY_CLKS - 1);

  state_e      state_q, state_d;
  logic        ph_q, ph_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic        busy_q, busy_d;
  logic        fsclk_q, fsclk_d;
  logic        fcen_q, fcen_d;
  logic [3:0]  fdo_q, fdo_d;
  logic [3:0]  fdoe_q, fdoe_d;
  logic [23:0] adr;

  // states in which chip select is low and fsclk toggles
  function automatic logic is_frame(input state_e s);
`ifdef FLASH_RSTSEQ_EN
    return s inside {S_CMD, S_ADDR, S_DUMMY, S_DATA, S_RST66, S_RST99};
`else
    return s inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
`endif
  endfunction

  // sequencer: arbitration, bit-period stepping, nibble capture
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    sh_d      = sh_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    if (is_frame(state_q)) begin
      ph_d = ~ph_q;
      if (ph_q) cnt_d = cnt_q + 7'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          gnt_d   = bus.d_req && (!bus.i_req || !last_q);
          state_d = S_CMD;
          ph_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      S_CMD: begin
        if (ph_q && cnt_q == 7'd7) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        if (ph_q && cnt_q == 7'd23) begin
          state_d = S_DUMMY;
          cnt_d   = '0;
        end
      end
      S_DUMMY: begin
        if (ph_q && cnt_q == DUMMY_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (ph_q) sh_d = {sh_q[27:0], fdi};
        if (ph_q && cnt_q == 7'd7) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          i_done_d = !gnt_q;
          d_done_d = gnt_q;
          if (gnt_q)
            d_rdata_d = {sh_d[7:0], sh_d[15:8], sh_d[23:16], sh_d[31:24]};
          else
            i_rdata_d = {sh_d[7:0], sh_d[15:8], sh_d[23:16], sh_d[31:24]};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = gnt_q;
      end
`ifdef FLASH_RSTSEQ_EN
      S_INIT: state_d = S_RST66;
      S_RST66: begin
        if (ph_q && cnt_q == 7'd7) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd1) begin
          state_d = S_RST99;
          cnt_d   = '0;
        end
      end
      S_RST99: begin
        if (ph_q && cnt_q == 7'd7) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd63) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // pad outputs registered from the next state so they align with it
  always_comb begin
    adr     = gnt_d ? bus.d_addr : bus.i_addr;
    fcen_d  = ~is_frame(state_d);
    fsclk_d = is_frame(state_d) & ph_d;
    busy_d  = state_d != S_IDLE;
    fdoe_d  = '0;
    fdo_d   = '0;
    unique case (state_d)
      S_CMD: begin
        fdoe_d   = 4'b0001;
        fdo_d[0] = RD_CMD[~cnt_d[2:0]];
      end
      S_ADDR: begin
        fdoe_d   = 4'b0001;
        fdo_d[0] = adr[5'd23 - cnt_d[4:0]];
      end
`ifdef FLASH_RSTSEQ_EN
      S_RST66: begin
        fdoe_d   = 4'b0001;
        fdo_d[0] = OP_RSTEN[~cnt_d[2:0]];
      end
      S_RST99: begin
        fdoe_d   = 4'b0001;
        fdo_d[0] = OP_RST[~cnt_d[2:0]];
      end
`endif
      default: ;
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= S_RESET;
      ph_q      <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      sh_q      <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      busy_q    <= 1'b0;
      fsclk_q   <= 1'b0;
      fcen_q    <= 1'b1;
      fdo_q     <= '0;
      fdoe_q    <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      sh_q      <= sh_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      busy_q    <= busy_d;
      fsclk_q   <= fsclk_d;
      fcen_q    <= fcen_d;
      fdo_q     <= fdo_d;
      fdoe_q    <= fdoe_d;
    end
  end

  assign bus.i_done  = i_done_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_done  = d_done_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.busy    = busy_q;
  assign fsclk       = fsclk_q;
  assign fcen        = fcen_q;
  assign fdo         = fdo_q;
  assign fdoe        = fdoe_q;

endmodule

// File: doc/qspi_flash_arbiter.md
# qspi_flash_arbiter

Quad-SPI flash read controller that shares the single external flash pad group (fdi/fdo/fdoe/fsclk/fcen) between two on-chip requesters: an instruction-fetch port and a data port. It arbitrates between them, sequences one Fast Read Quad Output transaction per grant, assembles the 32-bit read word and returns it with a one-cycle done pulse. It sits between the AHB flash slave logic and the fdio/fsclk/fcen pad cells of the SoC.

## Interface
- RD_CMD, 8'h6B: read opcode shifted out in the command phase.
- DUMMY_CLKS, 8: number of fsclk periods in the dummy phase; legal range 1..15.
- HCLK  in  1  system clock; the only clock.
- HRESETn  in  1  reset; synchronous and active-low.
- i_req  in  1  instruction-port request; level, held until i_done.
- i_addr  in  24  instruction byte address; stable while i_req is high.
- i_done  out  1  one-cycle pulse, i_rdata valid.
- i_rdata  out  32  instruction read word.
- d_req, d_addr, d_done, d_rdata: same as the i_* ports, for the data port.
- busy  out  1  high from accept until the DONE state, inclusive.
- fdi  in  4  flash IO pad inputs.
- fdo  out  4  flash IO pad outputs.
- fdoe  out  4  flash IO output enables (1 = drive).
- fsclk  out  1  flash serial clock.
- fcen  out  1  flash chip enable, active-low.

## Operation
- FSM states: IDLE, CMD, ADDR, DUMMY, DATA, DONE. With FLASH_RSTSEQ_EN, INIT states are added (see Configuration).
- IDLE: fcen=1, fsclk=0, fdoe=0000. If any request is high, grant and move to CMD on the next edge.
- Arbitration:
  - Round-robin via a last_grant flop. When both requests are high, grant the port not served last. When only one is high, grant it.
  - After reset last_grant=data, so the instruction port wins the first tie.
- Bit period: two HCLK cycles.
  - Phase 0: fsclk=0; fdo is updated at its start.
  - Phase 1: fsclk=1.
- CMD: RD_CMD is sent MSB first on fdo[0], 8 periods, fdoe=0001. Pad pull-ups hold WP#/HOLD# high.
- ADDR: the granted address, 24 bits, MSB first on fdo[0], fdoe=0001.
- DUMMY: DUMMY_CLKS periods, fdoe=0000, fdo=0000.
- DATA:
  - 8 nibble periods, fdoe=0000.
  - fdi is sampled on the HCLK edge that ends phase 1.
  - Byte k (address order) goes to rdata[8k+7:8k], high nibble first, giving a little-endian word.
- DONE: one cycle.
  - fcen=1, fsclk=0.
  - The granted port's done pulses; its rdata is updated on that same edge and held until its next done.
  - last_grant is updated.
  - Next state is IDLE.
- Dropping req mid-transaction has no effect: the transaction completes and done still pulses.
- A req still high in IDLE after its done is a new request.
- Ungranted requests wait; there is no timeout.

## Timing
- Reset values: fcen=1, fsclk=0, fdo=0, fdoe=0, i_done=d_done=0, i_rdata=d_rdata=0, busy=0, FSM=IDLE (INIT with macro), last_grant=data.
- Reset is synchronous: asserting it mid-transaction forces the reset values at the next edge, with no done pulse. A request still held after release restarts from CMD.
- Accept edge E0: fcen=0 and fsclk=0 in cycle 1 after E0.
- fcen low for 2*(40+DUMMY_CLKS) cycles, which is 96 by default.
- done is high in cycle 97 by default. Number of fsclk rising edges per transaction: 40+DUMMY_CLKS.
- fcen high for at least 2 cycles (DONE+IDLE) between transactions.
- Back-to-back throughput: one word per 98 cycles by default.
- fsclk, fcen, fdo and fdoe are registered outputs.

## Configuration
- FLASH_RSTSEQ_EN defined:
  - After reset, the FSM sends opcode 0x66 (one 8-period CS frame, fdoe=0001).
  - It then holds fcen high 2 cycles, sends 0x99 the same way, and holds fcen high 64 cycles.
  - It then enters IDLE. Requests are held off (busy=1) until IDLE.
- FLASH_RSTSEQ_EN undefined: IDLE directly after reset; no INIT logic is present.

## Test plan
- Single read: i_req, i_addr=0x000100; flash model returns 11 22 33 44 → i_rdata=0x44332211; i_done in cycle 97 after accept; fcen low 96 cycles; 48 fsclk rising edges.
- Serial format: capture fdo[0] on fsclk rising edges during the same read → 0x6B then 0x000100 MSB first. fdoe=0001 for 64 cycles, then 0000.
- Arbitration: i_req and d_req held high from reset for 3 transactions → grant order I, D, I. d_rdata matches the data-port address contents.
- Reset mid-DATA: HRESETn low 1 cycle at cycle 90 → next edge fcen=1, fdoe=0, no done. d_req still high → fresh CMD 0x6B; correct d_done about 97 cycles later.
- d_req dropped in ADDR phase → transaction completes and d_done pulses; IDLE is then entered with no new request.
- With FLASH_RSTSEQ_EN: after reset, fdo[0] shows 0x66, fcen high 2 cycles, then 0x99, then 64 idle cycles. An i_req asserted during init is served after, with i_done correct.
